run_ctrl: RTL

Run-control sequencer for the single-cycle computer. It gates execution through a single clock-enable (`cpu_en`) that the top level ANDs into the PC load, register A/B loads, data-memory write and status-register update. It accepts HALT/RUN/STEP/SET_BP commands over a valid/ready port. It supports N-instruction stepping and a single PC breakpoint, and keeps a count of executed cycles.

---
 rtl/run_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run-control sequencer for the single-cycle computer.
//
// Produces one execute-enable (cpu_en_o) that the top level ANDs into every
// architectural state update. Accepts HALT/RUN/STEP/SET_BP commands over a
// valid/ready port. Supports N-instruction stepping, one PC breakpoint, and
// an executed-cycle counter.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   cmd_valid_i    command present
//   cmd_ready_o    command accepted when cmd_valid_i && cmd_ready_o
//   cmd_op_i       00 HALT, 01 RUN, 10 STEP, 11 SET_BP
//   cmd_arg_i      STEP: count; SET_BP: [PC_W-1:0] address, [PC_W] enable
//   pc_i           current PC of the computer
//   cpu_en_o       execute-enable for the current cycle
//   state_o        00 HALTED, 01 RUNNING, 10 STEPPING
//   bp_hit_o       one-cycle pulse: stopped by the breakpoint
//   done_o         one-cycle pulse: step count exhausted
//   cmd_err_o      one-cycle pulse: accepted command was dropped
//   cycle_count_o  cycles with cpu_en_o=1 since reset (wraps)
module run_ctrl #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [CNT_W-1:0] cmd_arg_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             cpu_en_o,
    output logic [1:0]       state_o,
    output logic             bp_hit_o,
    output logic             done_o,
    output logic             cmd_err_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    typedef enum logic [1:0] {
        StHalted   = 2'b00,
        StRunning  = 2'b01,
        StStepping = 2'b10
    } state_e;

    localparam logic [1:0] OpHalt  = 2'b00;
    localparam logic [1:0] OpRun   = 2'b01;
    localparam logic [1:0] OpStep  = 2'b10;
    localparam logic [1:0] OpSetBp = 2'b11;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   bp_addr_q, bp_addr_d;
    logic              bp_en_q, bp_en_d;
    logic [CNT_W-1:0]  steps_q, steps_d;
    logic              skip_q, skip_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic              bp_hit_q, bp_hit_d;
    logic              done_q, done_d;
    logic              cmd_err_q, cmd_err_d;

    logic active;
    logic bp_match;
    logic cmd_acc;

    assign active   = (state_q == StRunning) || (state_q == StStepping);
    // Skip flag masks the breakpoint for the first enabled cycle after a
    // resume, so execution can leave a breakpoint address.
    assign bp_match = bp_en_q && (pc_i == bp_addr_q) && !skip_q;

    assign cmd_ready_o = !rst_i;
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;

    // Depends only on registered state and pc_i, never on command inputs.
    assign cpu_en_o = !rst_i && active && !bp_match;

    always_comb begin
        state_d     = state_q;
        bp_addr_d   = bp_addr_q;
        bp_en_d     = bp_en_q;
        steps_d     = steps_q;
        skip_d      = skip_q;
        cycle_cnt_d = cycle_cnt_q;
        bp_hit_d    = 1'b0;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;

        // Execution bookkeeping for the current cycle.
        if (active && bp_match) begin
            state_d  = StHalted;
            steps_d  = '0;
            bp_hit_d = 1'b1;
        end else if (cpu_en_o) begin
            cycle_cnt_d = cycle_cnt_q + CntOne;
            skip_d      = 1'b0;
            if (state_q == StStepping) begin
                steps_d = steps_q - CntOne;
                if (steps_q == CntOne) begin
                    state_d = StHalted;
                    done_d  = 1'b1;
                end
            end
        end

        // Commands. RUN/STEP only act from HALTED, where nothing above fires,
        // so the two sections never fight over the same registers.
        if (cmd_acc) begin
            unique case (cmd_op_i)
                OpHalt: begin
                    if (active) begin
                        state_d = StHalted;
                        steps_d = '0;
                    end
                end
                OpRun: begin
                    if (state_q == StHalted) begin
                        state_d = StRunning;
                        skip_d  = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                OpStep: begin
                    if (state_q == StHalted && cmd_arg_i != '0) begin
                        state_d = StStepping;
                        steps_d = cmd_arg_i;
                        skip_d  = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                OpSetBp: begin
                    bp_addr_d = cmd_arg_i[PC_W-1:0];
                    bp_en_d   = cmd_arg_i[PC_W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StHalted;
            bp_addr_q   <= '0;
            bp_en_q     <= 1'b0;
            steps_q     <= '0;
            skip_q      <= 1'b0;
            cycle_cnt_q <= '0;
            bp_hit_q    <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bp_addr_q   <= bp_addr_d;
            bp_en_q     <= bp_en_d;
            steps_q     <= steps_d;
            skip_q      <= skip_d;
            cycle_cnt_q <= cycle_cnt_d;
            bp_hit_q    <= bp_hit_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign state_o       = state_q;
    assign bp_hit_o      = bp_hit_q;
    assign done_o        = done_q;
    assign cmd_err_o     = cmd_err_q;
    assign cycle_count_o = cycle_cnt_q;

endmodule
